// File: rtl/riscv_pkg.sv
// Shared control definitions: opcode map, sequencer state encoding and
// PC source selects. Also imported by the control decoder.
package riscv_pkg;

    typedef enum logic [6:0] {
        OP_R      = 7'b0110011,
        OP_LOAD   = 7'b0000011,
        OP_IALU   = 7'b0010011,
        OP_STORE  = 7'b0100011,
        OP_BRANCH = 7'b1100011,
        OP_AUIPC  = 7'b0010111,
        OP_LUI    = 7'b0110111,
        OP_JAL    = 7'b1101111,
        OP_JALR   = 7'b1100111
    } opcode_e;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DECODE  = 3'd1,
        ST_EXECUTE = 3'd2,
        ST_MEM     = 3'd3,
        ST_WB      = 3'd4,
        ST_TRAP    = 3'd5
    } state_e;

    localparam logic [1:0] PC_SEL_PLUS4 = 2'b00;
    localparam logic [1:0] PC_SEL_REL   = 2'b01;
    localparam logic [1:0] PC_SEL_ALU   = 2'b10;

    // True for every opcode the sequencer knows how to retire.
    function automatic logic is_legal(input logic [6:0] op);
        case (op)
            OP_R, OP_LOAD, OP_IALU, OP_STORE, OP_BRANCH,
            OP_AUIPC, OP_LUI, OP_JAL, OP_JALR: is_legal = 1'b1;
            default:                           is_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/perf_counters.sv
// Free-running cycle counter and retired-instruction counter, both
// wrapping silently at 2^CNT_W.
module perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_cycle,
    input  logic             en_instret,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    logic [1:0]            cnt_en;
    logic [1:0][CNT_W-1:0] cnt_bus;

    assign cnt_en = {en_instret, en_cycle};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // One enable-gated wrapping counter per slot.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg <= '0;
                end else if (cnt_en[gi]) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end

            assign cnt_bus[gi] = cnt_reg;
        end
    endgenerate

    assign cycle_cnt   = cnt_bus[0];
    assign instret_cnt = cnt_bus[1];

endmodule

// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer: FETCH/DECODE/EXECUTE/MEM/WB with an
// absorbing TRAP state for unknown opcodes, plus performance counters.
module multicycle_sequencer #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             ir_en,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             reg_we,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic [2:0]       state_o,
    output logic             illegal,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    import riscv_pkg::*;

    state_e state_reg;
    state_e state_next;
    logic   illegal_reg;
    logic   is_mem_op;
    logic   is_store;

    assign is_store  = (opcode == OP_STORE);
    assign is_mem_op = (opcode == OP_LOAD) || is_store;

    // State register; reset aborts whatever instruction is in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic driven by handshakes and the held opcode.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_FETCH: begin
                if (imem_ready) state_next = ST_DECODE;
            end
            ST_DECODE: begin
                state_next = is_legal(opcode) ? ST_EXECUTE : ST_TRAP;
            end
            ST_EXECUTE: begin
                if (opcode == OP_BRANCH) state_next = ST_FETCH;
                else if (is_mem_op)      state_next = ST_MEM;
                else                     state_next = ST_WB;
            end
            ST_MEM: begin
                if (dmem_ready) state_next = is_store ? ST_FETCH : ST_WB;
            end
            ST_WB:   state_next = ST_FETCH;
            ST_TRAP: state_next = ST_TRAP;
            default: state_next = ST_FETCH;
        endcase
    end

    // Sticky illegal flag, raised when DECODE rejects the opcode.
    always_ff @(posedge clk) begin
        if (rst) begin
            illegal_reg <= 1'b0;
        end else if (state_reg == ST_DECODE && !is_legal(opcode)) begin
            illegal_reg <= 1'b1;
        end
    end

    // Output decode; everything is held at zero while reset is asserted.
    always_comb begin
        imem_req = 1'b0;
        ir_en    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        reg_we   = 1'b0;
        pc_en    = 1'b0;
        pc_sel   = PC_SEL_PLUS4;
        state_o  = 3'd0;
        illegal  = 1'b0;
        if (!rst) begin
            state_o = state_reg;
            illegal = illegal_reg;
            case (state_reg)
                ST_FETCH: begin
                    imem_req = 1'b1;
                    ir_en    = imem_ready;
                end
                ST_EXECUTE: begin
                    if (opcode == OP_BRANCH) begin
                        pc_en  = 1'b1;
                        pc_sel = branch_taken ? PC_SEL_REL : PC_SEL_PLUS4;
                    end
                end
                ST_MEM: begin
                    dmem_req = 1'b1;
                    dmem_we  = is_store;
                    pc_en    = is_store && dmem_ready;
                end
                ST_WB: begin
                    reg_we = 1'b1;
                    pc_en  = 1'b1;
                    if (opcode == OP_JAL)       pc_sel = PC_SEL_REL;
                    else if (opcode == OP_JALR) pc_sel = PC_SEL_ALU;
                end
                default: ;
            endcase
        end
    end

    perf_counters #(
        .CNT_W(CNT_W)
    ) u_perf (
        .clk         (clk),
        .rst         (rst),
        .en_cycle    (1'b1),
        .en_instret  (pc_en),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed latency table, trap and reset
// corner sequences, counter wrap on a 4-bit instance, and random traffic
// checked cycle by cycle against a trace built from the instruction rules.
module tb_multicycle_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode;
    logic        branch_taken, imem_ready, dmem_ready;

    logic        imem_req, ir_en, dmem_req, dmem_we, reg_we, pc_en, illegal;
    logic [1:0]  pc_sel;
    logic [2:0]  state_o;
    logic [31:0] cycle_cnt, instret_cnt;

    logic        imem_req4, ir_en4, dmem_req4, dmem_we4, reg_we4, pc_en4, illegal4;
    logic [1:0]  pc_sel4;
    logic [2:0]  state_o4;
    logic [3:0]  cycle_cnt4, instret_cnt4;

    always #5 clk = ~clk;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .reg_we(reg_we), .pc_en(pc_en), .pc_sel(pc_sel), .state_o(state_o),
        .illegal(illegal), .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    multicycle_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .opcode(opcode), .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req4), .ir_en(ir_en4), .dmem_req(dmem_req4), .dmem_we(dmem_we4),
        .reg_we(reg_we4), .pc_en(pc_en4), .pc_sel(pc_sel4), .state_o(state_o4),
        .illegal(illegal4), .cycle_cnt(cycle_cnt4), .instret_cnt(instret_cnt4)
    );

    localparam logic [6:0] R_OP  = 7'b0110011, LD_OP = 7'b0000011, IA_OP = 7'b0010011;
    localparam logic [6:0] ST_OP = 7'b0100011, BR_OP = 7'b1100011, AU_OP = 7'b0010111;
    localparam logic [6:0] LU_OP = 7'b0110111, JL_OP = 7'b1101111, JR_OP = 7'b1100111;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    // One cycle of stimulus plus the outputs required in that cycle.
    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic       bt, ir, dr;
        logic [2:0] st;
        logic       imq, ire, dmq, dwe, rwe, pce;
        logic [1:0] sel;
        logic       ill;
    } cyc_t;

    typedef struct {
        logic [6:0] op;
        logic       bt;
        int         wi, wd;
        int         lat;
        logic [1:0] sel;
        int         rwe;
    } vec_t;

    int          n_vec = 0, n_err = 0;
    logic [31:0] mc, mi;              // reference counter values
    int          g_n, g_lat, g_rwe;   // per-instruction measurements
    logic [1:0]  g_sel;
    logic [31:0] s_cyc, s_ins;
    logic [3:0]  s_cyc4, s_ins4;
    logic        s_ill, s_imq;

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s at t=%0t: got %0h want %0h", nm, $time, got, want);
        end
    endtask

    function automatic cyc_t mk(input logic [6:0] op, input logic [2:0] st);
        cyc_t c;
        c = '0;
        c.op = op;
        c.st = st;
        c.bt = 1'($urandom);
        c.ir = 1'($urandom);
        c.dr = 1'($urandom);
        return c;
    endfunction

    // Apply one cycle, compare both instances, then advance the reference counters.
    task automatic cyc(input cyc_t c);
        logic [11:0] want;
        @(negedge clk);
        rst = c.rst; opcode = c.op; branch_taken = c.bt;
        imem_ready = c.ir; dmem_ready = c.dr;
        #1;
        want = {c.st, c.imq, c.ire, c.dmq, c.dwe, c.rwe, c.pce, c.sel, c.ill};
        chk("ctl", {state_o, imem_req, ir_en, dmem_req, dmem_we, reg_we, pc_en, pc_sel, illegal}, want);
        chk("ctl4", {state_o4, imem_req4, ir_en4, dmem_req4, dmem_we4, reg_we4, pc_en4, pc_sel4, illegal4}, want);
        chk("cycle_cnt", cycle_cnt, mc);
        chk("instret_cnt", instret_cnt, mi);
        chk("cycle_cnt4", cycle_cnt4, mc[3:0]);
        chk("instret_cnt4", instret_cnt4, mi[3:0]);
        g_n++;
        if (pc_en && g_lat == 0) begin g_lat = g_n; g_sel = pc_sel; end
        if (reg_we) g_rwe++;
        s_cyc = cycle_cnt; s_ins = instret_cnt; s_cyc4 = cycle_cnt4; s_ins4 = instret_cnt4;
        s_ill = illegal; s_imq = imem_req;
        @(posedge clk);
        if (c.rst) begin mc = 0; mi = 0; end
        else begin mc = mc + 1; if (c.pce) mi = mi + 1; end
    endtask

    task automatic do_reset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = mk(7'($urandom), 3'd0);
            c.rst = 1'b1;
            cyc(c);
        end
    endtask

    task automatic fetch_idle();
        cyc_t c;
        c = mk(7'($urandom), 3'd0);
        c.imq = 1'b1; c.ir = 1'b0;
        cyc(c);
    endtask

    // Drive one legal instruction with the given ready wait counts, expecting
    // the cycle sequence the instruction class calls for.
    task automatic run_instr(input logic [6:0] op, input logic bt, input int wi, input int wd);
        cyc_t c;
        logic is_st, is_ld;
        is_st = (op == ST_OP);
        is_ld = (op == LD_OP);
        g_n = 0; g_lat = 0; g_rwe = 0; g_sel = 2'b11;
        for (int i = 0; i < wi; i++) fetch_idle();
        c = mk(7'($urandom), 3'd0);
        c.imq = 1'b1; c.ir = 1'b1; c.ire = 1'b1;
        cyc(c);
        cyc(mk(op, 3'd1));
        c = mk(op, 3'd2);
        if (op == BR_OP) begin
            c.bt = bt; c.pce = 1'b1; c.sel = bt ? 2'b01 : 2'b00;
            cyc(c);
            return;
        end
        cyc(c);
        if (is_st || is_ld) begin
            for (int i = 0; i < wd; i++) begin
                c = mk(op, 3'd3);
                c.dmq = 1'b1; c.dwe = is_st; c.dr = 1'b0;
                cyc(c);
            end
            c = mk(op, 3'd3);
            c.dmq = 1'b1; c.dwe = is_st; c.dr = 1'b1; c.pce = is_st;
            cyc(c);
            if (is_st) return;
        end
        c = mk(op, 3'd4);
        c.rwe = 1'b1; c.pce = 1'b1;
        c.sel = (op == JL_OP) ? 2'b01 : (op == JR_OP) ? 2'b10 : 2'b00;
        cyc(c);
    endtask

    vec_t       tbl[13];
    logic [6:0] legal_ops[9];

    initial begin
        cyc_t        c;
        logic [31:0] ins_hold, cyc_hold;

        tbl[0]  = '{R_OP,  1'b0, 0, 0, 4, 2'b00, 1};
        tbl[1]  = '{LD_OP, 1'b0, 0, 3, 8, 2'b00, 1};
        tbl[2]  = '{BR_OP, 1'b1, 0, 0, 3, 2'b01, 0};
        tbl[3]  = '{BR_OP, 1'b0, 0, 0, 3, 2'b00, 0};
        tbl[4]  = '{ST_OP, 1'b0, 0, 0, 4, 2'b00, 0};
        tbl[5]  = '{JL_OP, 1'b0, 0, 0, 4, 2'b01, 1};
        tbl[6]  = '{JR_OP, 1'b0, 0, 0, 4, 2'b10, 1};
        tbl[7]  = '{LU_OP, 1'b0, 0, 0, 4, 2'b00, 1};
        tbl[8]  = '{AU_OP, 1'b0, 0, 0, 4, 2'b00, 1};
        tbl[9]  = '{IA_OP, 1'b0, 0, 0, 4, 2'b00, 1};
        tbl[10] = '{LD_OP, 1'b0, 0, 0, 5, 2'b00, 1};
        tbl[11] = '{ST_OP, 1'b0, 1, 2, 7, 2'b00, 0};
        tbl[12] = '{R_OP,  1'b0, 2, 0, 6, 2'b00, 1};
        legal_ops = '{R_OP, LD_OP, IA_OP, ST_OP, BR_OP, AU_OP, LU_OP, JL_OP, JR_OP};

        rst = 1'b1; opcode = '0; branch_taken = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
        repeat (2) @(posedge clk);
        mc = 0; mi = 0;
        do_reset(2);

        // Directed latency / pc_sel / reg_we table.
        for (int i = 0; i < 13; i++) begin
            run_instr(tbl[i].op, tbl[i].bt, tbl[i].wi, tbl[i].wd);
            chk($sformatf("lat[%0d]", i), g_lat, tbl[i].lat);
            chk($sformatf("pc_sel[%0d]", i), g_sel, tbl[i].sel);
            chk($sformatf("reg_we[%0d]", i), g_rwe, tbl[i].rwe);
            $display("vec %0d op=%b lat=%0d sel=%0d rwe=%0d", i, tbl[i].op, g_lat, g_sel, g_rwe);
            if (i == 0) begin
                fetch_idle();
                chk("instret_after_first", s_ins, 32'd1);
            end
        end

        // Unknown opcode: trap absorbs, counters freeze except cycle_cnt.
        c = mk(7'($urandom), 3'd0);
        c.imq = 1'b1; c.ir = 1'b1; c.ire = 1'b1;
        cyc(c);
        cyc(mk(BAD_OP, 3'd1));
        ins_hold = mi; cyc_hold = mc;
        for (int i = 0; i < 10; i++) begin
            c = mk(BAD_OP, 3'd5);
            c.ill = 1'b1;
            cyc(c);
        end
        chk("trap_illegal", s_ill, 1'b1);
        chk("trap_instret", s_ins, ins_hold);
        chk("trap_cycle", s_cyc, cyc_hold + 32'd9);
        $display("trap: illegal=%0d instret=%0d cycle=%0d", s_ill, s_ins, s_cyc);
        do_reset(2);
        chk("trap_cleared", s_ill, 1'b0);

        // Reset while a store waits in MEM: aborted, no retire.
        fetch_idle();
        c = mk(7'($urandom), 3'd0);
        c.imq = 1'b1; c.ir = 1'b1; c.ire = 1'b1;
        cyc(c);
        cyc(mk(ST_OP, 3'd1));
        cyc(mk(ST_OP, 3'd2));
        for (int i = 0; i < 2; i++) begin
            c = mk(ST_OP, 3'd3);
            c.dmq = 1'b1; c.dwe = 1'b1; c.dr = 1'b0;
            cyc(c);
        end
        c = mk(ST_OP, 3'd0);
        c.rst = 1'b1; c.dr = 1'b1;
        cyc(c);
        do_reset(1);
        fetch_idle();
        chk("post_rst_imem_req", s_imq, 1'b1);
        chk("post_rst_instret", s_ins, 32'd0);
        $display("rst-in-mem: imem_req=%0d instret=%0d", s_imq, s_ins);

        // Sixteen back-to-back R-types wrap both 4-bit counters.
        do_reset(1);
        for (int i = 0; i < 16; i++) run_instr(R_OP, 1'b0, 0, 0);
        fetch_idle();
        chk("wrap_cycle4", s_cyc4, 4'd0);
        chk("wrap_instret4", s_ins4, 4'd0);
        chk("wrap_cycle32", s_cyc, 32'd64);
        chk("wrap_instret32", s_ins, 32'd16);
        $display("wrap: cycle4=%0d instret4=%0d cycle=%0d instret=%0d", s_cyc4, s_ins4, s_cyc, s_ins);

        // Random legal traffic with random wait states.
        for (int k = 0; k < 250; k++) begin
            logic [6:0] op;
            logic       bt;
            int         wi, wd;
            op = legal_ops[$urandom_range(0, 8)];
            bt = 1'($urandom);
            wi = $urandom_range(0, 3);
            wd = $urandom_range(0, 3);
            run_instr(op, bt, wi, wd);
            $display("rnd %0d op=%b bt=%0d wi=%0d wd=%0d lat=%0d", k, op, bt, wi, wd, g_lat);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
